// File: rtl/pc_sequencer.sv
// Next-PC selection and fetch-stall controller: picks sequential/branch/trap/mret
// targets, holds the PC across multi-cycle ops with a bounded wait, and records trap state.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          MC_TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_addr,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        mc_req,
  input  logic        mc_done,
  input  logic        trap_req,
  input  logic [3:0]  trap_cause,
  input  logic [31:0] trap_vector,
  input  logic        mret,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] next_pc,
  output logic        no_update,
  output logic [31:0] epc,
  output logic [3:0]  cause,
  output logic [1:0]  state,
  output logic        mc_timeout
);

  // state   | meaning
  // RUN     | normal fetch, redirects evaluated by priority
  // MC_WAIT | PC held while a multi-cycle op completes
  // HALT    | PC held until resume
  // ERR     | multi-cycle op timed out; exit only via reset
  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MC_WAIT = 2'd1,
    S_HALT    = 2'd2,
    S_ERR     = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(MC_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_epc;
  logic [3:0]  r_cause;
  logic [15:0] r_cnt;
  logic        r_mc_timeout;

  logic [31:0] w_seq;
  logic [31:0] w_pc_sel;
  logic        w_hold;
  logic        w_capture;
  logic [3:0]  w_cap_cause;
  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic        w_set_timeout;

  assign w_seq = instr_addr + 32'd4;

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_sel      = w_seq;
    w_hold        = 1'b0;
    w_capture     = 1'b0;
    w_cap_cause   = trap_cause;
    w_cnt_clr     = 1'b0;
    w_cnt_inc     = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      S_RUN: begin
        if (trap_req) begin
          w_pc_sel  = trap_vector;
          w_capture = 1'b1;
        end else if (halt_req) begin
          w_hold      = 1'b1;
          w_state_nxt = S_HALT;
        end else if (mc_req && !mc_done) begin
          w_hold      = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_MC_WAIT;
        end else if (mc_req && mc_done) begin
          w_pc_sel = w_seq;
        end else if (mret) begin
          w_pc_sel = r_epc;
        end else if (branch_taken && (branch_target[1:0] == 2'b00)) begin
          w_pc_sel = branch_target;
        end else if (branch_taken) begin
          // misaligned target is handled as a trap with cause 0
          w_pc_sel    = trap_vector;
          w_capture   = 1'b1;
          w_cap_cause = 4'h0;
        end
      end
      S_MC_WAIT: begin
        w_cnt_inc = 1'b1;
        if (mc_done) begin
          w_state_nxt = S_RUN;
        end else begin
          w_hold = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt   = S_ERR;
            w_set_timeout = 1'b1;
          end
        end
      end
      S_HALT: begin
        w_hold = 1'b1;
        if (resume) w_state_nxt = S_RUN;
      end
      default: begin
        w_hold = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_RUN;
      r_epc        <= 32'h0;
      r_cause      <= 4'h0;
      r_cnt        <= 16'h0;
      r_mc_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_epc   <= instr_addr;
        r_cause <= w_cap_cause;
      end
      if (w_cnt_clr)      r_cnt <= 16'h0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 16'd1;
      if (w_set_timeout)  r_mc_timeout <= 1'b1;
    end
  end

  // While held, present seq so no stale redirect value lingers on next_pc.
  assign no_update  = !reset_n || w_hold;
  assign next_pc    = !reset_n ? RESET_VECTOR : (w_hold ? w_seq : w_pc_sel);
  assign epc        = r_epc;
  assign cause      = r_cause;
  assign state      = r_state;
  assign mc_timeout = r_mc_timeout;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequential fetch, branches, traps,
// halt/resume, multi-cycle stall, timeout and PC wrap-around.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_addr;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        mc_req;
  logic        mc_done;
  logic        trap_req;
  logic [3:0]  trap_cause;
  logic [31:0] trap_vector;
  logic        mret;
  logic        halt_req;
  logic        resume;
  logic [31:0] next_pc;
  logic        no_update;
  logic [31:0] epc;
  logic [3:0]  cause;
  logic [1:0]  state;
  logic        mc_timeout;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.RESET_VECTOR(32'h0000_0100), .MC_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .instr_addr(instr_addr),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .mc_req(mc_req), .mc_done(mc_done), .trap_req(trap_req),
    .trap_cause(trap_cause), .trap_vector(trap_vector), .mret(mret),
    .halt_req(halt_req), .resume(resume), .next_pc(next_pc),
    .no_update(no_update), .epc(epc), .cause(cause), .state(state),
    .mc_timeout(mc_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; instr_addr = 32'h0; branch_taken = 1'b0; branch_target = 32'h0;
    mc_req = 1'b0; mc_done = 1'b0; trap_req = 1'b0; trap_cause = 4'h0;
    trap_vector = 32'h0000_8000; mret = 1'b0; halt_req = 1'b0; resume = 1'b0;
    #3;
    chk("rst_next_pc", next_pc, 32'h100);
    chk("rst_no_update", {31'b0, no_update}, 32'd1);
    chk("rst_state", {30'b0, state}, 32'd0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cause", {28'b0, cause}, 32'h0);
    chk("rst_timeout", {31'b0, mc_timeout}, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    instr_addr = 32'h100;
    #1;
    chk("seq_next_pc", next_pc, 32'h104);
    chk("seq_no_update", {31'b0, no_update}, 32'd0);
    chk("seq_state", {30'b0, state}, 32'd0);

    // aligned branch
    branch_taken = 1'b1; branch_target = 32'h2000; #1;
    chk("br_next_pc", next_pc, 32'h2000);
    chk("br_no_update", {31'b0, no_update}, 32'd0);
    tick();

    // trap beats halt and branch
    instr_addr = 32'h300; trap_req = 1'b1; trap_cause = 4'hB; halt_req = 1'b1; #1;
    chk("trap_next_pc", next_pc, 32'h8000);
    chk("trap_no_update", {31'b0, no_update}, 32'd0);
    tick();
    chk("trap_epc", epc, 32'h300);
    chk("trap_cause", {28'b0, cause}, 32'hB);
    chk("trap_state", {30'b0, state}, 32'd0);
    trap_req = 1'b0; branch_taken = 1'b0; instr_addr = 32'h8000; #1;
    chk("halt_no_update", {31'b0, no_update}, 32'd1);
    chk("halt_next_pc", next_pc, 32'h8004);
    tick();
    chk("halt_state", {30'b0, state}, 32'd2);
    resume = 1'b1; #1;
    chk("halt_hold", {31'b0, no_update}, 32'd1);
    tick();
    chk("resume_state", {30'b0, state}, 32'd0);
    halt_req = 1'b0; resume = 1'b0; mret = 1'b1; #1;
    chk("mret_next_pc", next_pc, 32'h300);
    chk("mret_no_update", {31'b0, no_update}, 32'd0);
    tick();
    mret = 1'b0;

    // misaligned branch -> trap with cause 0
    instr_addr = 32'h204; branch_taken = 1'b1; branch_target = 32'h2002; #1;
    chk("mis_next_pc", next_pc, 32'h8000);
    tick();
    chk("mis_epc", epc, 32'h204);
    chk("mis_cause", {28'b0, cause}, 32'h0);
    branch_taken = 1'b0;

    // multi-cycle stall, mc_done 3 cycles after mc_req
    instr_addr = 32'h40; mc_req = 1'b1; #1;
    chk("mc_hold0", {31'b0, no_update}, 32'd1);
    tick();
    chk("mc_state", {30'b0, state}, 32'd1);
    chk("mc_hold1", {31'b0, no_update}, 32'd1);
    tick();
    trap_req = 1'b1; trap_cause = 4'h7; branch_taken = 1'b1; branch_target = 32'h2000; #1;
    chk("mc_hold2", {31'b0, no_update}, 32'd1);
    chk("mc_ignore_pc", next_pc, 32'h44);
    tick();
    trap_req = 1'b0; branch_taken = 1'b0; mc_done = 1'b1; #1;
    chk("mc_done_no_update", {31'b0, no_update}, 32'd0);
    chk("mc_done_next_pc", next_pc, 32'h44);
    tick();
    mc_req = 1'b0; mc_done = 1'b0;
    chk("mc_back_run", {30'b0, state}, 32'd0);
    chk("mc_epc_kept", epc, 32'h204);

    // mc_req with mc_done together: no stall
    instr_addr = 32'h60; mc_req = 1'b1; mc_done = 1'b1; #1;
    chk("mc_fast_no_update", {31'b0, no_update}, 32'd0);
    chk("mc_fast_next_pc", next_pc, 32'h64);
    tick();
    chk("mc_fast_state", {30'b0, state}, 32'd0);
    mc_done = 1'b0;

    // timeout: 4 MC_WAIT cycles then ERR
    instr_addr = 32'h80;
    tick(); tick(); tick(); tick();
    chk("to_wait_state", {30'b0, state}, 32'd1);
    chk("to_flag_low", {31'b0, mc_timeout}, 32'd0);
    tick();
    mc_req = 1'b0;
    chk("to_err_state", {30'b0, state}, 32'd3);
    chk("to_flag", {31'b0, mc_timeout}, 32'd1);
    chk("to_hold", {31'b0, no_update}, 32'd1);
    chk("to_next_pc", next_pc, 32'h84);
    tick();
    chk("to_err_stays", {30'b0, state}, 32'd3);
    reset_n = 1'b0; #1;
    chk("rst2_state", {30'b0, state}, 32'd0);
    chk("rst2_flag", {31'b0, mc_timeout}, 32'd0);
    chk("rst2_next_pc", next_pc, 32'h100);
    tick();
    reset_n = 1'b1;

    // restart a wait after reset: counter must be fresh
    mc_req = 1'b1;
    tick(); tick(); tick();
    mc_req = 1'b0;
    chk("rst2_cnt_clear", {30'b0, state}, 32'd1);
    mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    chk("rst2_run", {30'b0, state}, 32'd0);

    instr_addr = 32'hFFFF_FFFC; #1;
    chk("wrap_next_pc", next_pc, 32'h0);
    chk("wrap_no_update", {31'b0, no_update}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC selection and stall controller for the RV core. Each cycle it chooses the program counter's next value (sequential, branch target, trap vector or exception return) and drives the counter's `no_update` hold. It stalls fetch across multi-cycle instructions with a bounded wait, services halt/resume, and records trap state in `epc` and `cause`. It sits between decode/execute and the program counter.

## Interface
- `RESET_VECTOR`, 32'h0000_0000: `next_pc` value while reset is asserted.
- `MC_TIMEOUT`, 64: maximum cycles spent in MC_WAIT before entering ERR; legal range 2..65535.
- `clk` in 1: core clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `instr_addr` in 32: current PC from the program counter.
- `branch_taken` in 1: the current instruction redirects.
- `branch_target` in 32: redirect address.
- `mc_req` in 1: the current instruction is multi-cycle.
- `mc_done` in 1: the multi-cycle unit has finished; one-cycle pulse.
- `trap_req` in 1: take a trap at the current instruction.
- `trap_cause` in 4: cause code for `trap_req`.
- `trap_vector` in 32: trap handler address.
- `mret` in 1: return from trap.
- `halt_req` in 1: request to halt fetch.
- `resume` in 1: leave HALT.
- `next_pc` out 32: to the program counter.
- `no_update` out 1: to the program counter; 1 holds the PC.
- `epc` out 32: PC of the last trapped instruction.
- `cause` out 4: last trap cause.
- `state` out 2: RUN=0, MC_WAIT=1, HALT=2, ERR=3.
- `mc_timeout` out 1: sticky error flag.

## Operation
- The FSM, `epc`, `cause`, the wait counter and `mc_timeout` are registers.
- `next_pc` and `no_update` are combinational from the registered state and the current inputs.
- `seq` = `instr_addr + 4`, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- RUN evaluates conditions in this priority order; the first match applies:
  1. **trap_req**: `next_pc`=`trap_vector`, `no_update`=0; capture `epc`←`instr_addr`, `cause`←`trap_cause`.
  2. **halt_req**: `no_update`=1; go to HALT.
  3. **mc_req & !mc_done**: `no_update`=1; clear the counter; go to MC_WAIT.
  4. **mc_req & mc_done**: `next_pc`=`seq`, `no_update`=0; stay in RUN.
  5. **mret**: `next_pc`=`epc`, `no_update`=0.
  6. **branch_taken with `branch_target[1:0]`==0**: `next_pc`=`branch_target`, `no_update`=0.
  7. **branch_taken with `branch_target[1:0]`!=0** (misaligned): treat as a trap with cause 4'h0. `next_pc`=`trap_vector`, `epc`←`instr_addr`, `cause`←0.
  8. **otherwise**: `next_pc`=`seq`, `no_update`=0.
- MC_WAIT:
  - `no_update`=1 and the counter increments each cycle.
  - `mc_done`: `next_pc`=`seq`, `no_update`=0; go to RUN.
  - Counter == `MC_TIMEOUT`-1 and !`mc_done`: go to ERR and set `mc_timeout`. `mc_done` in that same cycle wins.
  - `trap_req`, `halt_req`, `mret` and `branch_taken` are ignored. Requesters hold them until RUN.
- HALT:
  - `no_update`=1.
  - `resume`: go to RUN. Fetch continues from the held PC on the following cycle.
  - `halt_req` together with `resume`: `resume` wins.
- ERR:
  - `no_update`=1 and `mc_timeout`=1.
  - Left only by reset.
- `next_pc` is `seq` whenever `no_update`=1, so it carries no stale redirect values.

## Timing
- Registers update on the rising edge of `clk`. The program counter samples `next_pc`/`no_update` on the falling edge, so the outputs settle within the high phase.
- While `reset_n`=0, with immediate asynchronous effect:
  - `state`=RUN, `epc`=0, `cause`=0, counter=0, `mc_timeout`=0.
  - `no_update`=1 and `next_pc`=`RESET_VECTOR`.
- First cycle after reset release: normal RUN evaluation.
- Redirect latency is zero cycles: the redirect value is presented in the same cycle as its request.
- A multi-cycle instruction with `mc_done` N cycles after `mc_req` (N≥1) holds the PC for exactly N cycles.
- Reset asserted mid-MC_WAIT or in ERR aborts to RUN with the counter cleared. The multi-cycle unit is reset by the same `reset_n`.
- `epc`/`cause` change only on a trap in RUN, including the misaligned-branch case.

## Test plan
- **Reset, then sequential fetch**: reset with `RESET_VECTOR`=32'h100, release, `instr_addr`=32'h100 → `next_pc`=32'h104, `no_update`=0, `state`=0.
- **Branch handling**: aligned branch to 32'h2000 → `next_pc`=32'h2000. Branch to 32'h2002 → `next_pc`=`trap_vector`, `epc`=`instr_addr`, `cause`=0.
- **Multi-cycle stall**: `mc_req`, then `mc_done` 3 cycles later at `instr_addr`=32'h40 → `no_update`=1 for 3 cycles, then `next_pc`=32'h44 and back in RUN. `mc_req` with `mc_done` in the same cycle → no stall.
- **Timeout**: `MC_TIMEOUT`=4 with `mc_req` and no `mc_done` → ERR after 4 MC_WAIT cycles, `mc_timeout`=1, `no_update` held. `reset_n` pulse → RUN, flag cleared.
- **Priority and trap return**: `trap_req` (cause 4'hB) together with `halt_req` and `branch_taken` → trap taken, `cause`=4'hB. Next cycle `halt_req` → HALT. `resume` → RUN. `mret` → `next_pc`=`epc`.
- **Wrap-around**: `instr_addr`=32'hFFFF_FFFC → `next_pc`=0.
